// File: rtl/fft_out_unloader_pkg.sv
// -----------------------------------------------------------------------------
// fft_out_unloader_pkg
// Shared constants, FSM state type and the digit-reversal helper used by the
// FFT output unloader. The reversal lives here so every block that forms a
// bank address from a group index uses the same mapping.
// -----------------------------------------------------------------------------
package fft_out_unloader_pkg;

  localparam int FFT_N      = 1024;                    // samples per transform
  localparam int BANK_DEPTH = 256;                     // words per bank
  localparam int BANK_AW    = 8;                       // bank address width
  localparam int NUM_BANKS  = 4;                       // A, B, C, D
  localparam int CNT_W      = $clog2(FFT_N);           // out_cnt width (10)
  localparam int GRP_W      = $clog2(BANK_DEPTH) + 1;  // issued-read counter, 0..256
  localparam int WORD_W     = $clog2(NUM_BANKS);       // word index within a group

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Radix-4 digit reversal of an 8-bit group index: the four 2-bit digits are
  // written out in reverse order.
  function automatic logic [BANK_AW-1:0] digit_rev(input logic [BANK_AW-1:0] k);
    return {k[1:0], k[3:2], k[5:4], k[7:6]};
  endfunction

endpackage

// File: rtl/fft_out_unloader_if.sv
// -----------------------------------------------------------------------------
// fft_out_unloader_if
// Bundles the unloader's control, bank-read and output-stream signals.
//   master : the unloader (drives busy/done, bank reads, the stream)
//   slave  : the surrounding system (controller, banks, stream sink)
// Signals:
//   start/busy/done        control handshake with the FFT controller
//   rd_en/rd_addr          common read strobe/address for banks A..D
//   a_q/b_q/c_q/d_q        bank read data, valid the cycle after rd_en
//   out_valid/out_ready    stream handshake
//   out_data/out_last/out_cnt  stream payload, last flag, sequence index
// -----------------------------------------------------------------------------
interface fft_out_unloader_if
  import fft_out_unloader_pkg::*;
#(
  parameter int DW = 32
) ();

  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [BANK_AW-1:0] rd_addr;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [DW-1:0]      c_q;
  logic [DW-1:0]      d_q;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic [CNT_W-1:0]   out_cnt;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_addr,
    input  a_q, b_q, c_q, d_q,
    output out_valid,
    input  out_ready,
    output out_data, out_last, out_cnt
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_addr,
    output a_q, b_q, c_q, d_q,
    input  out_valid,
    output out_ready,
    input  out_data, out_last, out_cnt
  );

endinterface

// File: rtl/fft_out_unloader_grp.sv
// -----------------------------------------------------------------------------
// fft_grp_buf
// Two-slot ping-pong buffer of 4-word groups between the bank read port and
// the output stream.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   reserve     claim the next slot for a read being issued this cycle
//   capture     write cap_words into the slot claimed by the in-flight read
//   cap_words   one group, word 0 = bank A ... word 3 = bank D
//   pop         consume the current head word
//   slot_free   the next slot in reservation order is unclaimed
//   head_valid  head slot holds captured data
//   head_word   current word of the head slot
// Slots are claimed and released in strict alternation, so a single write
// pointer and a single head pointer describe the whole state. Only one read
// is ever in flight, so the capture target is latched at reserve time.
// -----------------------------------------------------------------------------
module fft_grp_buf
  import fft_out_unloader_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reserve,
  input  logic                          capture,
  input  logic [NUM_BANKS-1:0][DW-1:0]  cap_words,
  input  logic                          pop,
  output logic                          slot_free,
  output logic                          head_valid,
  output logic [DW-1:0]                 head_word
);

  logic [NUM_BANKS-1:0][DW-1:0] slot_q [2];
  logic [1:0]        resv_q;   // slot claimed (from issue until its last pop)
  logic [1:0]        full_q;   // slot holds captured data
  logic              wr_ptr_q; // next slot to claim
  logic              cap_ptr_q;// slot the in-flight read lands in
  logic              head_q;   // slot being streamed out
  logic [WORD_W-1:0] word_q;   // word index within the head slot
  logic              pop_ok;
  logic              pop_free;

  assign pop_ok   = pop && full_q[head_q];
  assign pop_free = pop_ok && (word_q == WORD_W'(NUM_BANKS - 1));

  // NOTE: the data slots carry no reset; their full flags below do, and a
  // slot is never read unless its flag is set, so clearing the payload would
  // only add reset fan-out.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_q[cap_ptr_q] <= cap_words;
    end
  end

  // NOTE: state registers are updated only with non-blocking assignments so
  // every read in this block sees the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_q    <= '0;
      full_q    <= '0;
      wr_ptr_q  <= 1'b0;
      cap_ptr_q <= 1'b0;
      head_q    <= 1'b0;
      word_q    <= '0;
    end else begin
      if (reserve) begin
        resv_q[wr_ptr_q] <= 1'b1;
        cap_ptr_q        <= wr_ptr_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      // Capture lands in the reserved slot, which is never the head slot
      // being freed, so both updates can share one edge.
      if (capture) begin
        full_q[cap_ptr_q] <= 1'b1;
      end
      if (pop_ok) begin
        if (pop_free) begin
          resv_q[head_q] <= 1'b0;
          full_q[head_q] <= 1'b0;
          head_q         <= ~head_q;
          word_q         <= '0;
        end else begin
          word_q <= word_q + WORD_W'(1);
        end
      end
    end
  end

  assign slot_free  = ~resv_q[wr_ptr_q];
  assign head_valid = full_q[head_q];
  assign head_word  = slot_q[head_q][word_q];

endmodule

// File: rtl/fft_out_unloader.sv
// -----------------------------------------------------------------------------
// fft_out_unloader
// Drains a finished 1024-point transform from banks A..D as a serial stream.
// Group k (0..255) is read at the digit-reversed address, and its four words
// go out in bank order A, B, C, D with valid/ready backpressure.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset; aborts any drain without done
//   bus   fft_out_unloader_if.master (start/busy/done, bank read port,
//         output stream)
// Timing with the sink always ready: start in cycle 0, first read in cycle 1,
// first sample in cycle 3, last sample in cycle 1026, done in cycle 1027.
// -----------------------------------------------------------------------------
module fft_out_unloader
  import fft_out_unloader_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_out_unloader_if.master    bus
);

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               rd_pend_q;  // bank data for the last read is on *_q now
  logic [BANK_AW-1:0] rd_addr_q;
  logic [GRP_W-1:0]   grp_q;      // reads issued so far in this run
  logic [CNT_W-1:0]   cnt_q;

  logic               slot_free;
  logic               head_valid;
  logic [DW-1:0]      head_word;
  logic               xfer;
  logic               last_xfer;
  logic               issue;
  logic [BANK_AW-1:0] grp_idx;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    xfer      = head_valid && bus.out_ready;
    last_xfer = xfer && (cnt_q == CNT_W'(FFT_N - 1));
    grp_idx   = grp_q[BANK_AW-1:0];
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        // The accepting edge already issues group 0.
        issue   = bus.start;
        grp_idx = '0;
      end
      RUN: begin
        // One read at a time: wait out both the strobe cycle and the
        // capture cycle before issuing the next one.
        issue = (grp_q != GRP_W'(BANK_DEPTH)) && !rd_en_q && !rd_pend_q
                && slot_free;
      end
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      grp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      rd_en_q   <= issue;
      rd_pend_q <= rd_en_q;
      done_q    <= 1'b0;
      if (issue) begin
        rd_addr_q <= digit_rev(grp_idx);
        grp_q     <= GRP_W'({1'b0, grp_idx}) + GRP_W'(1);
      end
      // The count stops at 1023 so it never wraps inside a run.
      if (xfer && !last_xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (last_xfer) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fft_grp_buf #(.DW(DW)) u_grp_buf (
    .clk        (clk),
    .rst        (rst),
    .reserve    (issue),
    .capture    (rd_pend_q),
    .cap_words  ({bus.d_q, bus.c_q, bus.b_q, bus.a_q}),
    .pop        (xfer),
    .slot_free  (slot_free),
    .head_valid (head_valid),
    .head_word  (head_word)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = head_valid;
  // Stale slot contents never reach the port while nothing is valid.
  assign bus.out_data  = head_valid ? head_word : '0;
  assign bus.out_last  = head_valid && (cnt_q == CNT_W'(FFT_N - 1));
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_fft_out_unloader.sv
// -----------------------------------------------------------------------------
// tb_fft_out_unloader
// Bank model with 1-cycle read latency, word = {bank, 0x00, addr}. Expected
// read addresses and stream words are queued at start and popped as the DUT
// issues reads and transfers samples.
// -----------------------------------------------------------------------------
module tb_fft_out_unloader;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_out_unloader_if #(.DW(DW)) bus ();

  fft_out_unloader #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] bank_word(input int b, input logic [7:0] a);
    return {16'(b), 8'h00, a};
  endfunction

  function automatic logic [7:0] rev4(input logic [7:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*(3-i) +: 2] = k[2*i +: 2];
    return r;
  endfunction

  // Banks: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_q <= bank_word(0, bus.rd_addr);
      bus.b_q <= bank_word(1, bus.rd_addr);
      bus.c_q <= bank_word(2, bus.rd_addr);
      bus.d_q <= bank_word(3, bus.rd_addr);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and run bookkeeping.
  logic [7:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int  t0 = 0;
  bit  mon_en = 1'b0;
  int  reads_issued, xfers, done_cnt;
  int  first_rd_rel, first_valid_rel, last_xfer_rel, done_rel, busy_fall_rel;
  bit  busy_seen, rd_d1, rd_d2, prev_stall, prev_last;
  logic [31:0] prev_data;
  logic [9:0]  prev_cnt;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (mon_en) begin
      if (bus.rd_en) begin
        if (first_rd_rel < 0) first_rd_rel = rel;
        check("rd_in_flight_once", 32'(rd_d1 || rd_d2), 0);
        if (exp_addr_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr_q.pop_front()));
        if (reads_issued == 8'h1B) check("rd_addr_grp1b", 32'(bus.rd_addr), 32'h0E4);
        reads_issued++;
      end
      if (bus.out_valid && first_valid_rel < 0) first_valid_rel = rel;
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_cnt", 32'(bus.out_cnt), 32'(prev_cnt));
        check("hold_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() == 0) check("xfer_extra", 1, 0);
        else check("out_data", bus.out_data, exp_data_q.pop_front());
        check("out_cnt", 32'(bus.out_cnt), 32'(xfers));
        check("out_last", 32'(bus.out_last), 32'(xfers == 1023));
        if (xfers == 1023) last_xfer_rel = rel;
        xfers++;
      end
      check("groups_buffered_le2", 32'((reads_issued - xfers / 4) <= 2), 1);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_cnt   = bus.out_cnt;
      prev_last  = bus.out_last;
      if (bus.done) begin
        done_rel = rel;
        done_cnt++;
      end
      if (bus.busy) busy_seen = 1'b1;
      else if (busy_seen && busy_fall_rel < 0) busy_fall_rel = rel;
      rd_d2 = rd_d1;
      rd_d1 = bus.rd_en;
      if (rst) begin
        prev_stall = 1'b0;
        rd_d1      = 1'b0;
        rd_d2      = 1'b0;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_rd_en"},     32'(bus.rd_en), 0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_last"},  32'(bus.out_last), 0);
    check({tag, "_out_cnt"},   32'(bus.out_cnt), 0);
  endtask

  // mode 0: ready always 1; 1: ready toggles; 2: ready low through cycle 52.
  task automatic run_scen(input int mode, input int restart_at,
                          input int rst_at, input bit timing);
    int  rel;
    bit  stop;
    @(posedge clk); #1;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < 256; k++) begin
      exp_addr_q.push_back(rev4(8'(k)));
      for (int b = 0; b < 4; b++) exp_data_q.push_back(bank_word(b, rev4(8'(k))));
    end
    reads_issued = 0; xfers = 0; done_cnt = 0;
    first_rd_rel = -1; first_valid_rel = -1; last_xfer_rel = -1;
    done_rel = -1; busy_fall_rel = -1;
    busy_seen = 1'b0; rd_d1 = 1'b0; rd_d2 = 1'b0; prev_stall = 1'b0;
    t0 = cyc;
    bus.start     = 1'b1;
    bus.out_ready = (mode == 0);
    @(negedge clk);
    check("busy_in_start_cycle", 32'(bus.busy), 0);
    stop = 1'b0;
    while (!stop) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      rel = cyc - t0;
      case (mode)
        1:       bus.out_ready = rel[0];
        2:       bus.out_ready = (rel >= 53);
        default: bus.out_ready = 1'b1;
      endcase
      if (rel == 1) check("busy_after_start", 32'(bus.busy), 1);
      if (rel == restart_at) bus.start = 1'b1;
      if (mode == 2 && rel == 52) check("stall_reads_issued", 32'(reads_issued), 2);
      if (rst_at >= 0 && bus.out_valid && bus.out_cnt == 10'(rst_at)) begin
        check("rd_in_flight_at_rst", 32'(bus.rd_en), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_rst");
        stop = 1'b1;
      end
      if (done_cnt > 0 && rel > done_rel + 1) stop = 1'b1;
      if (rel > 3000) begin
        check("run_timeout", 0, 1);
        stop = 1'b1;
      end
    end
    if (rst_at < 0) begin
      check("done_pulses", 32'(done_cnt), 1);
      check("samples_out", 32'(xfers), 1024);
      check("reads_out", 32'(reads_issued), 256);
      check("sb_data_left", 32'(exp_data_q.size()), 0);
      if (timing) begin
        check("first_rd_cycle", 32'(first_rd_rel), 1);
        check("first_valid_cycle", 32'(first_valid_rel), 3);
        check("last_xfer_cycle", 32'(last_xfer_rel), 1026);
        check("done_cycle", 32'(done_rel), 1027);
        check("busy_fall_cycle", 32'(busy_fall_rel), 1028);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    mon_en = 1'b1;
    run_scen(0, -1, -1, 1'b1);   // full rate
    run_scen(1, -1, -1, 1'b0);   // ready toggling
    run_scen(2, -1, -1, 1'b0);   // long stall after first valid
    run_scen(0, 100, -1, 1'b1);  // start while busy is ignored
    run_scen(0, -1, 517, 1'b0);  // reset mid-drain
    run_scen(0, -1, -1, 1'b1);   // fresh run after the abort
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
